// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, one step per cycle.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   localparam logic [2:0] OpMult  = 3'd0;
   localparam logic [2:0] OpMultu = 3'd1;
   localparam logic [2:0] OpDiv   = 3'd2;
   localparam logic [2:0] OpDivu  = 3'd3;
   localparam logic [2:0] OpMthi  = 3'd4;
   localparam logic [2:0] OpMtlo  = 3'd5;

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e              state_q;
   logic [CntW-1:0]     cnt_q;
   logic                busy_q;
   logic                done_q;
   logic                dbz_out_q;
   logic                div_q;
   logic                neg_a_q;
   logic                neg_b_q;
   logic                zero_q;
   logic [WIDTH-1:0]    opa_q;
   logic [WIDTH-1:0]    opb_q;
   logic [2*WIDTH-1:0]  acc_q;
   logic [WIDTH-1:0]    hi_q;
   logic [WIDTH-1:0]    lo_q;

   // Operand decode in IDLE
   logic             op_signed;
   logic             op_div;
   logic             rs_neg;
   logic             rt_neg;
   logic [WIDTH-1:0] rs_mag;
   logic [WIDTH-1:0] rt_mag;

   always_comb begin
      op_signed = (op == OpMult) || (op == OpDiv);
      op_div    = (op == OpDiv) || (op == OpDivu);
      rs_neg    = op_signed && rs_data[WIDTH-1];
      rt_neg    = op_signed && rt_data[WIDTH-1];
      rs_mag    = rs_neg ? -rs_data : rs_data;
      rt_mag    = rt_neg ? -rt_data : rt_data;
   end

   // One iteration of each algorithm. For divide, acc holds {remainder, dividend/quotient}.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opb_q};
      if (div_diff[WIDTH]) begin
         div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
   end

   // Sign correction applied in FIX
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   always_comb begin
      prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
      quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      if (!div_q) begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end else if (zero_q) begin
         // Restores the raw dividend from its magnitude and sign
         fix_hi = neg_a_q ? -opa_q : opa_q;
         fix_lo = '1;
      end else begin
         fix_hi = rem_fix;
         fix_lo = quo_fix;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
         div_q     <= 1'b0;
         neg_a_q   <= 1'b0;
         neg_b_q   <= 1'b0;
         zero_q    <= 1'b0;
         opa_q     <= '0;
         opb_q     <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  case (op)
                     OpMult, OpMultu, OpDiv, OpDivu: begin
                        state_q <= StCalc;
                        busy_q  <= 1'b1;
                        cnt_q   <= CntW'(WIDTH);
                        div_q   <= op_div;
                        neg_a_q <= rs_neg;
                        neg_b_q <= rt_neg;
                        zero_q  <= op_div && (rt_data == '0);
                        opa_q   <= rs_mag;
                        opb_q   <= rt_mag;
                        acc_q   <= op_div ? {{WIDTH{1'b0}}, rs_mag} : {{WIDTH{1'b0}}, rt_mag};
                     end
                     OpMthi:  hi_q <= rs_data;
                     OpMtlo:  lo_q <= rs_data;
                     default: ;
                  endcase
               end
            end
            StCalc: begin
               acc_q <= div_q ? div_next : mul_next;
               cnt_q <= cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               hi_q      <= fix_hi;
               lo_q      <= fix_lo;
               done_q    <= 1'b1;
               dbz_out_q <= zero_q;
               busy_q    <= 1'b0;
               state_q   <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_out_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32) against a plain-arithmetic reference model.
module tb_muldiv_unit;

   localparam int Lat = 34;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   // Reference model straight from the architectural rules
   function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el,
                                  output logic ed);
      longint      sa, sb, sp, q, r;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ed = 1'b0;
      eh = '0;
      el = '0;
      case (o)
         3'd0: begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; end
         3'd1: begin up = {32'd0, a} * {32'd0, b}; eh = up[63:32]; el = up[31:0]; end
         3'd2, 3'd3: begin
            if (b == 0) begin
               el = '1; eh = a; ed = 1'b1;
            end else if (o == 3'd2) begin
               q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0];
            end else begin
               el = a / b; eh = a % b;
            end
         end
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 20));
         3:       return -32'($urandom_range(1, 20));
         4:       return 32'($urandom_range(0, 1));
         default: return $urandom();
      endcase
   endfunction

   // Issue one arithmetic op in the current cycle; return at the done cycle (or on timeout)
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy1);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      @(posedge clk); #1;
      start = 1'b0;
      busy1 = busy;
      lat   = 1;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({hi, lo} !== 64'd0) begin
         failures++; $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo);
      end
      checks++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, div_by_zero});
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_multiply();
      logic [31:0] da[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000};
      logic [31:0] db[4] = '{32'h0000_0002, 32'h0000_0002, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [2:0]  dop[4] = '{3'd0, 3'd1, 3'd0, 3'd1};
      logic [31:0] a, b, eh, el;
      logic [2:0]  o;
      logic        ed, busy1;
      int          lat;
      for (int i = 0; i < 24; i++) begin
         if (i < 4) begin a = da[i]; b = db[i]; o = dop[i]; end
         else begin a = pick(); b = pick(); o = 3'($urandom_range(0, 1)); end
         ref_op(o, a, b, eh, el, ed);
         run_op(o, a, b, lat, busy1);
         checks++;
         if (lat !== Lat || busy1 !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mul_timing op=%0d got lat=%0d busy1=%b busy_done=%b exp lat=%0d 1 0",
                     o, lat, busy1, busy, Lat);
         end
         checks++;
         if (hi !== eh || lo !== el || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL mul_result op=%0d a=%h b=%h got=%h_%h dbz=%b exp=%h_%h dbz=0",
                     o, a, b, hi, lo, div_by_zero, eh, el);
         end
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || hi !== eh || lo !== el) begin
            failures++;
            $display("FAIL mul_pulse got done=%b hilo=%h_%h exp done=0 hilo=%h_%h",
                     done, hi, lo, eh, el);
         end
      end
   endtask

   task automatic test_divide();
      logic [31:0] da[5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0007, 32'hFFFF_FFF9,
                             32'h0000_0064};
      logic [31:0] db[5] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000,
                             32'hFFFF_FFF9};
      logic [2:0]  dop[5] = '{3'd2, 3'd2, 3'd3, 3'd2, 3'd3};
      logic [31:0] a, b, eh, el;
      logic [2:0]  o;
      logic        ed, busy1;
      int          lat;
      for (int i = 0; i < 25; i++) begin
         if (i < 5) begin a = da[i]; b = db[i]; o = dop[i]; end
         else begin a = pick(); b = pick(); o = 3'($urandom_range(2, 3)); end
         ref_op(o, a, b, eh, el, ed);
         run_op(o, a, b, lat, busy1);
         checks++;
         if (lat !== Lat || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL div_timing op=%0d got lat=%0d busy1=%b exp lat=%0d busy1=1",
                     o, lat, busy1, Lat);
         end
         checks++;
         if (hi !== eh || lo !== el || div_by_zero !== ed) begin
            failures++;
            $display("FAIL div_result op=%0d a=%h b=%h got=%h_%h dbz=%b exp=%h_%h dbz=%b",
                     o, a, b, hi, lo, div_by_zero, eh, el, ed);
         end
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL div_pulse got done=%b dbz=%b exp 0 0", done, div_by_zero);
         end
      end
   endtask

   task automatic test_moves();
      logic [31:0] vh, vl;
      for (int i = 0; i < 4; i++) begin
         vh = $urandom(); vl = $urandom();
         start = 1'b1; op = 3'd4; rs_data = vh;
         @(posedge clk); #1;
         op = 3'd5; rs_data = vl;
         checks++;
         if (hi !== vh || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL mthi got hi=%h busy=%b done=%b exp %h 0 0", hi, busy, done, vh);
         end
         @(posedge clk); #1;
         op = 3'(6 + (i % 2)); rs_data = ~vl;
         checks++;
         if (lo !== vl || hi !== vh || busy !== 1'b0) begin
            failures++; $display("FAIL mtlo got hilo=%h_%h busy=%b exp %h_%h 0", hi, lo, busy, vh, vl);
         end
         @(posedge clk); #1;
         start = 1'b0;
         checks++;
         if (hi !== vh || lo !== vl || busy !== 1'b0) begin
            failures++; $display("FAIL nop got hilo=%h_%h busy=%b exp %h_%h 0", hi, lo, busy, vh, vl);
         end
      end
   endtask

   // MTHI held high throughout CALC and FIX must never land
   task automatic test_fix_ignore();
      logic [31:0] eh, el;
      logic        ed;
      int          lat;
      ref_op(3'd0, 32'h1234_5678, 32'hFFFF_FFF0, eh, el, ed);
      start = 1'b1; op = 3'd0; rs_data = 32'h1234_5678; rt_data = 32'hFFFF_FFF0;
      @(posedge clk); #1;
      op = 3'd4; rs_data = 32'hA5A5_A5A5;
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      checks++;
      if (lat !== Lat || hi !== eh || lo !== el) begin
         failures++;
         $display("FAIL fix_ignore got lat=%0d hilo=%h_%h exp lat=%0d hilo=%h_%h", lat, hi, lo,
                  Lat, eh, el);
      end
      @(posedge clk); #1;
      checks++;
      if (hi !== eh) begin
         failures++; $display("FAIL fix_ignore_after got hi=%h exp %h", hi, eh);
      end
   endtask

   task automatic test_ignore_and_reset();
      logic [31:0] lo_before;
      logic        busy1;
      int          lat;
      start = 1'b1; op = 3'd4; rs_data = 32'h1234_5678;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (hi !== 32'h1234_5678) begin
         failures++; $display("FAIL mthi_seq got hi=%h exp 12345678", hi);
      end
      lo_before = lo;
      start = 1'b1; op = 3'd1; rs_data = 32'h0000_1000; rt_data = 32'h0000_0003;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 10; c++) begin
         if (c == 5) begin
            start = 1'b1; op = 3'd5; rs_data = 32'hDEAD_BEEF;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      checks++;
      if (lo !== lo_before || busy !== 1'b1) begin
         failures++; $display("FAIL mtlo_busy got lo=%h busy=%b exp %h 1", lo, busy, lo_before);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
         failures++; $display("FAIL async_reset got hilo=%h_%h busy=%b exp 0_0 0", hi, lo, busy);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      run_op(3'd1, 32'd3, 32'd5, lat, busy1);
      checks++;
      if (lat !== Lat || hi !== 32'd0 || lo !== 32'd15) begin
         failures++;
         $display("FAIL post_reset_mul got lat=%0d hilo=%h_%h exp %0d 0_f", lat, hi, lo, Lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, eh, el;
      logic [2:0]  o;
      logic        ed, busy1;
      int          lat;
      for (int i = 0; i < 8; i++) begin
         a = pick(); b = pick(); o = 3'($urandom_range(0, 3));
         ref_op(o, a, b, eh, el, ed);
         // Next op issued in this op's done cycle
         run_op(o, a, b, lat, busy1);
         checks++;
         if (lat !== Lat || busy1 !== 1'b1 || hi !== eh || lo !== el || div_by_zero !== ed) begin
            failures++;
            $display("FAIL b2b op=%0d a=%h b=%h got lat=%0d busy1=%b %h_%h dbz=%b exp %0d 1 %h_%h %b",
                     o, a, b, lat, busy1, hi, lo, div_by_zero, Lat, eh, el, ed);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_multiply();
      test_divide();
      test_moves();
      test_fix_ignore();
      test_ignore_and_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit that owns the architectural HI and LO registers for the MIPS datapath. The single-cycle ALU multiply and divide paths are replaced by this unit. It runs signed and unsigned multiply (radix-2 shift-add) and divide (restoring) over WIDTH iterations behind a start/busy/done handshake, and also handles the MTHI and MTLO writes.

## Interface
- WIDTH, default 32: operand width. Must be even and at least 4. HI and LO are each WIDTH bits.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe. Sampled only in IDLE.
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO. Codes 6 and 7 are no-ops.
- rs_data  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- rt_data  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an arithmetic operation is in flight.
- done  out  1  one-cycle pulse when hi/lo take an arithmetic result.
- div_by_zero  out  1  pulses with done when a DIV or DIVU had rt_data == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with start=1 and op=MULT/MULTU/DIV/DIVU:
  - Latch the operand magnitudes, the result-sign flags, the op, and the zero-divisor flag.
  - Load the iteration counter with WIDTH and go to CALC.
  - For unsigned ops, magnitude = raw value. For signed ops, magnitude = two's-complement absolute value.
- IDLE with start=1 and op=MTHI: hi <= rs_data. op=MTLO: lo <= rs_data.
  - State stays IDLE; busy and done stay 0.
- IDLE with start=1 and op=6/7: no effect.
- CALC: one iteration per cycle; the counter decrements each cycle. When the counter reaches 0, go to FIX.
  - Multiply: 2·WIDTH-bit unsigned shift-add on the magnitudes.
  - Divide: restoring division on the magnitudes. Produces a WIDTH-bit quotient and a WIDTH-bit remainder.
- FIX: apply the sign correction and write hi/lo. Assert done on the next cycle; return to IDLE.
  - MULT: if the operand signs differ, negate the 2·WIDTH product. hi = upper half, lo = lower half.
  - MULTU: hi/lo = the unsigned product halves.
  - DIV: quotient is negated if the operand signs differ; remainder takes the dividend's sign. lo = quotient, hi = remainder.
  - DIVU: lo = quotient, hi = remainder.
- Divide by zero (rt_data == 0):
  - Full latency is preserved.
  - lo = all ones and hi = rs_data, for both DIV and DIVU, with no sign correction.
  - div_by_zero = 1 alongside done.
- Signed overflow (DIV of the most negative value by -1): lo = the most negative value, hi = 0. No flag is raised.
- start while busy, or while in FIX, is ignored entirely, including MTHI/MTLO.
- hi and lo hold their values between writes and are read directly by the datapath.

## Timing
- Reset (asynchronous, effective immediately):
  - state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, counter = 0.
  - A reset mid-operation discards the operation; hi/lo read 0.
- Handshake for start sampled at edge t (arithmetic op):
  - busy = 1 in cycles t+1 through t+WIDTH+1.
  - At edge t+WIDTH+1, hi/lo update.
  - In cycle t+WIDTH+2: done = 1, busy = 0, new hi/lo visible.
  - Total latency: WIDTH+2 cycles from the start cycle to the done cycle. For WIDTH=32 that is 34.
- A new start is accepted in the done cycle itself (back-to-back operations).
- MTHI/MTLO: hi/lo are visible in the cycle after the start cycle. Single-cycle.
- done and div_by_zero are registered outputs, high for exactly one cycle per operation.
- busy is registered: decoded from state != IDLE.

## Test plan
- MULT, rs=0xFFFFFFFF, rt=0x00000002 (WIDTH=32) -> 34 cycles after start: hi=0xFFFFFFFF, lo=0xFFFFFFFE, done for 1 cycle.
- MULTU, same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV, rs=0xFFFFFFF9 (-7), rt=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV, rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU, rs=7, rt=0 -> lo=0xFFFFFFFF, hi=0x00000007, div_by_zero=1 with done.
- MTHI 0x12345678 while idle -> hi=0x12345678 next cycle.
  - Then start MULTU. An MTLO issued at cycle 5 of the operation is ignored.
  - Assert reset at cycle 10 -> hi=lo=0, busy=0 at once.
  - A subsequent MULTU 3×5 gives lo=15, hi=0 at 34 cycles.
